// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl: sequences CPU reset on start, counts RUN cycles, detects halt/timeout
// Ports:
//   clk_i          system clock, all state on rising edge
//   rst_ni         asynchronous active-low reset of this block
//   start_i        single-cycle run request (honoured in IDLE/HALT/TIMEOUT)
//   pc_i           current fetch PC from CPU
//   inst_i         current fetched instruction from CPU
//   cpu_rst_o      active-high CPU reset, registered
//   running_o      high while in RUN
//   done_o         high in HALT or TIMEOUT
//   halted_o       run ended by halt detection
//   timeout_o      run ended by watchdog
//   cycle_count_o  RUN cycles elapsed in current/last run
//   final_pc_o     pc sampled on the cycle the run ended
`timescale 1ns/1ps
module pipeline_run_ctrl #(
    parameter int                   ADDR_LEN    = 32,
    parameter int                   INSTR_LEN   = 32,
    parameter int                   RST_CYCLES  = 1,
    parameter int                   MAX_CYCLES  = 50,
    parameter int                   HALT_REPEAT = 3,
    parameter int                   HALT_MODE   = 3,
    parameter logic [INSTR_LEN-1:0] HALT_INST   = 'h0000000C,
    parameter int                   CNT_W       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [ADDR_LEN-1:0]  pc_i,
    input  logic [INSTR_LEN-1:0] inst_i,
    output logic                 cpu_rst_o,
    output logic                 running_o,
    output logic                 done_o,
    output logic                 halted_o,
    output logic                 timeout_o,
    output logic [CNT_W-1:0]     cycle_count_o,
    output logic [ADDR_LEN-1:0]  final_pc_o
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    // stall counter only needs to reach HALT_REPEAT-2 before the firing sample
    localparam int SW = (HALT_REPEAT > 2) ? $clog2(HALT_REPEAT - 1) : 1;
    localparam logic [RW-1:0]    RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [SW-1:0]    STALL_LIM = SW'(HALT_REPEAT - 2);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
    localparam bit LOOP_EN = (HALT_MODE & 1) != 0;
    localparam bit INST_EN = (HALT_MODE & 2) != 0;

    typedef enum logic [2:0] {IDLE, RESET, RUN, HALT, TIMEOUT} state_e;

    state_e              state_q;
    logic [RW-1:0]       rst_cnt_q;
    logic [SW-1:0]       stall_q;
    logic [ADDR_LEN-1:0] pc_q;
    logic                pc_valid_q;
    logic                cpu_rst_q, running_q, done_q, halted_q, timeout_q;
    logic [CNT_W-1:0]    cycle_count_q;
    logic [ADDR_LEN-1:0] final_pc_q;
    logic                same_pc, loop_hit, inst_hit, halt_hit;

    always_comb begin
        same_pc  = pc_valid_q && (pc_i == pc_q);
        // the current sample is the HALT_REPEAT-th identical one
        loop_hit = LOOP_EN && same_pc && (stall_q == STALL_LIM);
        inst_hit = INST_EN && (inst_i == HALT_INST);
        halt_hit = loop_hit || inst_hit;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            rst_cnt_q     <= '0;
            stall_q       <= '0;
            pc_q          <= '0;
            pc_valid_q    <= 1'b0;
            cpu_rst_q     <= 1'b1;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            halted_q      <= 1'b0;
            timeout_q     <= 1'b0;
            cycle_count_q <= '0;
            final_pc_q    <= '0;
        end else begin
            case (state_q)
                IDLE, HALT, TIMEOUT: begin
                    if (start_i) begin
                        state_q       <= RESET;
                        rst_cnt_q     <= '0;
                        stall_q       <= '0;
                        pc_valid_q    <= 1'b0;
                        cycle_count_q <= '0;
                        done_q        <= 1'b0;
                        halted_q      <= 1'b0;
                        timeout_q     <= 1'b0;
                    end
                end
                RESET: begin
                    rst_cnt_q <= rst_cnt_q + RW'(1);
                    if (rst_cnt_q == RST_LAST) begin
                        state_q   <= RUN;
                        cpu_rst_q <= 1'b0;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    cycle_count_q <= cycle_count_q + CNT_W'(1);
                    pc_q          <= pc_i;
                    pc_valid_q    <= 1'b1;
                    stall_q       <= !same_pc ? '0 : (stall_q == STALL_LIM) ? stall_q : stall_q + SW'(1);
                    if (halt_hit || cycle_count_q == CNT_LAST) begin
                        state_q    <= halt_hit ? HALT : TIMEOUT;
                        halted_q   <= halt_hit;
                        timeout_q  <= !halt_hit;
                        done_q     <= 1'b1;
                        running_q  <= 1'b0;
                        cpu_rst_q  <= 1'b1;
                        final_pc_q <= pc_i;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_rst_o     = cpu_rst_q;
    assign running_o     = running_q;
    assign done_o        = done_q;
    assign halted_o      = halted_q;
    assign timeout_o     = timeout_q;
    assign cycle_count_o = cycle_count_q;
    assign final_pc_o    = final_pc_q;
endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// tb_pipeline_run_ctrl: directed self-checking bench for pipeline_run_ctrl
`timescale 1ns/1ps
module tb_pipeline_run_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] inst_i = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic        d_cpu_rst, d_running, d_done, d_halted, d_timeout;
    logic [15:0] d_cnt;
    logic [31:0] d_fpc;
    logic        h_cpu_rst, h_running, h_done, h_halted, h_timeout;
    logic [15:0] h_cnt;
    logic [31:0] h_fpc;
    logic        r_cpu_rst, r_running, r_done, r_halted, r_timeout;
    logic [15:0] r_cnt;
    logic [31:0] r_fpc;

    always #5 clk_i = ~clk_i;

    pipeline_run_ctrl u_def (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .pc_i(pc_i), .inst_i(inst_i),
        .cpu_rst_o(d_cpu_rst), .running_o(d_running), .done_o(d_done), .halted_o(d_halted),
        .timeout_o(d_timeout), .cycle_count_o(d_cnt), .final_pc_o(d_fpc)
    );

    pipeline_run_ctrl #(.HALT_MODE(2)) u_hm2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .pc_i(pc_i), .inst_i(inst_i),
        .cpu_rst_o(h_cpu_rst), .running_o(h_running), .done_o(h_done), .halted_o(h_halted),
        .timeout_o(h_timeout), .cycle_count_o(h_cnt), .final_pc_o(h_fpc)
    );

    pipeline_run_ctrl #(.RST_CYCLES(4)) u_rc4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .pc_i(pc_i), .inst_i(inst_i),
        .cpu_rst_o(r_cpu_rst), .running_o(r_running), .done_o(r_done), .halted_o(r_halted),
        .timeout_o(r_timeout), .cycle_count_o(r_cnt), .final_pc_o(r_fpc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    // start pulse plus the RESET window of the default-config instance
    task automatic begin_run;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
    endtask

    initial begin
        // reset values, asserted asynchronously
        #2 rst_ni = 1'b0;
        #1;
        check("rst_cpu_rst", {31'b0, d_cpu_rst}, 32'd1);
        check("rst_done", {31'b0, d_done}, 32'd0);
        check("rst_cnt", {16'b0, d_cnt}, 32'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        repeat (5) tick();
        check("idle_cpu_rst", {31'b0, d_cpu_rst}, 32'd1);
        check("idle_done", {31'b0, d_done}, 32'd0);
        check("idle_running", {31'b0, d_running}, 32'd0);
        check("idle_cnt", {16'b0, d_cnt}, 32'd0);

        // watchdog timeout, pc incrementing
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("to_rst_window", {31'b0, d_cpu_rst}, 32'd1);
        tick();
        check("to_rst_release", {31'b0, d_cpu_rst}, 32'd0);
        check("to_running", {31'b0, d_running}, 32'd1);
        for (int k = 1; k <= 50; k++) begin
            pc_i = 32'(4 * k);
            tick();
            if (k == 49) check("to_not_yet", {31'b0, d_timeout}, 32'd0);
        end
        check("to_timeout", {31'b0, d_timeout}, 32'd1);
        check("to_done", {31'b0, d_done}, 32'd1);
        check("to_halted", {31'b0, d_halted}, 32'd0);
        check("to_cnt", {16'b0, d_cnt}, 32'd50);
        check("to_fpc", d_fpc, 32'hC8);
        check("to_cpu_rst", {31'b0, d_cpu_rst}, 32'd1);
        tick();
        check("to_cnt_hold", {16'b0, d_cnt}, 32'd50);

        // re-run from TIMEOUT, then PC self-loop halt
        begin_run();
        check("rerun_cnt", {16'b0, d_cnt}, 32'd0);
        check("rerun_timeout", {31'b0, d_timeout}, 32'd0);
        check("rerun_done", {31'b0, d_done}, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            pc_i = (k <= 3) ? 32'(4 * (k - 1)) : 32'h10;
            tick();
            if (k == 5) check("loop_early", {31'b0, d_halted}, 32'd0);
        end
        check("loop_halted", {31'b0, d_halted}, 32'd1);
        check("loop_fpc", d_fpc, 32'h10);
        check("loop_timeout", {31'b0, d_timeout}, 32'd0);
        check("loop_cpu_rst", {31'b0, d_cpu_rst}, 32'd1);
        check("loop_cnt", {16'b0, d_cnt}, 32'd6);

        // HALT_MODE=2: halt instruction on RUN cycle 7
        do_reset();
        begin_run();
        for (int k = 1; k <= 7; k++) begin
            pc_i = 32'(4 * k);
            inst_i = (k == 7) ? 32'h0000000C : 32'h00000013;
            tick();
        end
        inst_i = '0;
        check("hm2_halted", {31'b0, h_halted}, 32'd1);
        check("hm2_cnt", {16'b0, h_cnt}, 32'd7);
        check("hm2_timeout", {31'b0, h_timeout}, 32'd0);

        // HALT_MODE=2 with constant pc: only the watchdog ends the run
        do_reset();
        begin_run();
        pc_i = 32'h40;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (k == 49) check("hm2_still_run", {31'b0, h_running}, 32'd1);
        end
        check("hm2_to", {31'b0, h_timeout}, 32'd1);
        check("hm2_to_halted", {31'b0, h_halted}, 32'd0);
        check("hm2_to_cnt", {16'b0, h_cnt}, 32'd50);

        // halt instruction on the watchdog cycle: halt wins
        do_reset();
        begin_run();
        for (int k = 1; k <= 50; k++) begin
            pc_i = 32'(4 * k);
            inst_i = (k == 50) ? 32'h0000000C : 32'h0;
            tick();
        end
        inst_i = '0;
        check("prio_halted", {31'b0, d_halted}, 32'd1);
        check("prio_timeout", {31'b0, d_timeout}, 32'd0);
        check("prio_cnt", {16'b0, d_cnt}, 32'd50);
        check("prio_fpc", d_fpc, 32'hC8);

        // asynchronous reset mid-run
        do_reset();
        begin_run();
        for (int k = 1; k <= 10; k++) begin
            pc_i = 32'(4 * k);
            tick();
        end
        check("mid_running", {31'b0, d_running}, 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("async_cpu_rst", {31'b0, d_cpu_rst}, 32'd1);
        check("async_running", {31'b0, d_running}, 32'd0);
        check("async_cnt", {16'b0, d_cnt}, 32'd0);
        check("async_fpc", d_fpc, 32'h0);
        check("async_done", {31'b0, d_done}, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // RST_CYCLES=4: cpu_rst high for exactly four cycles after start
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rc4_hold%0d", i), {31'b0, r_cpu_rst}, 32'd1);
            tick();
        end
        check("rc4_release", {31'b0, r_cpu_rst}, 32'd0);
        check("rc4_running", {31'b0, r_running}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
